sd_search_scheduler: RTL and testbench

- Shares one exhaustive depth-first sphere-decoding search engine between NUM_REQ requesters (one per receive channel/antenna group).
- Grants the engine round-robin, holds it in reset between jobs, steers the cost datapath to the granted channel, and waits for the engine's one-cycle completion pulse.
- Captures the engine's best-node symbols and returns them with requester ID, cycle count and timeout flag over a valid/ready result port.
- Sits between the per-channel front ends and the search engine / cost unit.

---
 rtl/sd_search_scheduler_if.sv | 41 ++++
 rtl/sd_search_scheduler.sv | 140 ++++++++++++++
 tb/tb_sd_search_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_search_scheduler_if.sv
// Handshake and datapath bundle between the search scheduler, the
// per-channel front ends, the search engine and the result consumer.
//
// Handshakes: a transfer happens on a rising Clk edge where both valid and
// ready are high. A valid, once raised, is held with its payload unchanged
// until the matching ready is seen. Ready may depend combinationally on
// valid (req_ready does); valid never depends on ready.
interface sd_search_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CYC_W   = 16
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic               eng_rst_n;
  logic [ID_W-1:0]    eng_sel;
  logic               eng_done;
  logic [11:0]        eng_best;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic [ID_W-1:0]    res_id;
  logic [11:0]        res_symbols;
  logic [CYC_W-1:0]   res_cycles;
  logic               res_timeout;
  logic [1:0]         dbg_state;

  modport master (
    input  req_valid, eng_done, eng_best, res_ready,
    output req_ready, eng_rst_n, eng_sel, busy,
    output res_valid, res_id, res_symbols, res_cycles, res_timeout,
    output dbg_state
  );

  modport slave (
    output req_valid, eng_done, eng_best, res_ready,
    input  req_ready, eng_rst_n, eng_sel, busy,
    input  res_valid, res_id, res_symbols, res_cycles, res_timeout,
    input  dbg_state
  );
endinterface

// File: rtl/sd_search_scheduler.sv
// Round-robin scheduler sharing one sphere-decoding search engine between
// NUM_REQ channels. The engine is held in reset outside a job, so every job
// starts clean; the result (best symbols, cycle count, timeout flag) is
// returned on a valid/ready port. dbg_state exposes the FSM: 0 IDLE, 1 RUN,
// 2 RESP.
module sd_search_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 8192
) (
  input  logic                  Clk,
  input  logic                  Reset,
  sd_search_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CYC_W-1:0] MAX_CNT  = CYC_W'(MAX_CYCLES);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

  state_t           state;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  eng_sel_q;
  logic [CYC_W-1:0] run_cnt;
  logic             eng_rst_n_q;
  logic             busy_q;
  logic             res_valid_q;
  logic [ID_W-1:0]  res_id_q;
  logic [11:0]      res_symbols_q;
  logic [CYC_W-1:0] res_cycles_q;
  logic             res_timeout_q;

  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  int               cand;
  logic [ID_W-1:0]  cand_id;

  // Round-robin search: first pending request after the last grant, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = 0;
    cand_id   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(last) + k) % NUM_REQ;
      cand_id = cand[ID_W-1:0];
      if (!grant_any && bus.req_valid[cand_id]) begin
        grant_any = 1'b1;
        grant_id  = cand_id;
      end
    end
  end

  // Accept is combinational so a job transfers in the cycle it is granted;
  // nothing is accepted while reset is asserted.
  assign bus.req_ready = (Reset && (state == IDLE) && grant_any)
                         ? (NUM_REQ'(1) << grant_id) : '0;

  assign bus.eng_rst_n   = eng_rst_n_q;
  assign bus.eng_sel     = eng_sel_q;
  assign bus.busy        = busy_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_id      = res_id_q;
  assign bus.res_symbols = res_symbols_q;
  assign bus.res_cycles  = res_cycles_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.dbg_state   = state;

  // Job FSM: grant in IDLE, count and capture in RUN, hold result in RESP.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      last          <= LAST_RST;
      eng_sel_q     <= '0;
      run_cnt       <= '0;
      eng_rst_n_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_symbols_q <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            eng_sel_q   <= grant_id;
            last        <= grant_id;
            run_cnt     <= '0;
            eng_rst_n_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          run_cnt <= run_cnt + CYC_W'(1);
          // Best symbols are taken in the done cycle: the engine clears them
          // on the following edge. Done beats a simultaneous timeout.
          if (bus.eng_done) begin
            res_symbols_q <= bus.eng_best;
            res_cycles_q  <= run_cnt + CYC_W'(1);
            res_timeout_q <= 1'b0;
            res_id_q      <= eng_sel_q;
            res_valid_q   <= 1'b1;
            eng_rst_n_q   <= 1'b0;
            state         <= RESP;
          end else if (run_cnt == LAST_CYC) begin
            res_symbols_q <= bus.eng_best;
            res_cycles_q  <= MAX_CNT;
            res_timeout_q <= 1'b1;
            res_id_q      <= eng_sel_q;
            res_valid_q   <= 1'b1;
            eng_rst_n_q   <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          eng_rst_n_q <= 1'b0;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_search_scheduler.sv
// Bench for sd_search_scheduler: two instances (default limit and a 64-cycle
// limit), a counting engine model per instance, and a result scoreboard.
module tb_sd_search_scheduler;

  localparam int RW = 2 + 12 + 16 + 1;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp2_q[$];

  sd_search_scheduler_if #(.NUM_REQ(4), .ID_W(2), .CYC_W(16)) sb ();
  sd_search_scheduler_if #(.NUM_REQ(4), .ID_W(2), .CYC_W(16)) sb2 ();

  sd_search_scheduler #(.NUM_REQ(4), .ID_W(2), .CYC_W(16), .MAX_CYCLES(8192)) dut (
    .Clk(Clk), .Reset(Reset), .bus(sb)
  );

  sd_search_scheduler #(.NUM_REQ(4), .ID_W(2), .CYC_W(16), .MAX_CYCLES(64)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(sb2)
  );

  // clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // engine models: pulse done on RUN cycle number done_at (0 = never)
  int          eng_cnt = 0, eng_cnt2 = 0;
  int          done_at = 0, done_at2 = 0;
  logic [11:0] best_val = 12'h000, best_val2 = 12'h000;

  always @(posedge Clk) begin
    if (!sb.eng_rst_n) eng_cnt <= 0; else eng_cnt <= eng_cnt + 1;
    if (!sb2.eng_rst_n) eng_cnt2 <= 0; else eng_cnt2 <= eng_cnt2 + 1;
  end

  assign sb.eng_done   = sb.eng_rst_n && (done_at != 0) && (eng_cnt + 1 == done_at);
  assign sb.eng_best   = best_val;
  assign sb2.eng_done  = sb2.eng_rst_n && (done_at2 != 0) && (eng_cnt2 + 1 == done_at2);
  assign sb2.eng_best  = best_val2;

  // scoreboard: compare each accepted result against the queued expectation
  always @(negedge Clk) begin
    logic [RW-1:0] e, g;
    if (sb.res_valid && sb.res_ready) begin
      checks++;
      g = {sb.res_id, sb.res_symbols, sb.res_cycles, sb.res_timeout};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dut_result_unexpected got=%h", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL dut_result got id=%0d sym=%h cyc=%0d to=%0b exp id=%0d sym=%h cyc=%0d to=%0b",
                   g[30:29], g[28:17], g[16:1], g[0], e[30:29], e[28:17], e[16:1], e[0]);
        end
      end
    end
    if (sb2.res_valid && sb2.res_ready) begin
      checks++;
      g = {sb2.res_id, sb2.res_symbols, sb2.res_cycles, sb2.res_timeout};
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL dut2_result_unexpected got=%h", g);
      end else begin
        e = exp2_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL dut2_result got id=%0d sym=%h cyc=%0d to=%0b exp id=%0d sym=%h cyc=%0d to=%0b",
                   g[30:29], g[28:17], g[16:1], g[0], e[30:29], e[28:17], e[16:1], e[0]);
        end
      end
    end
  end

  // wait until every queued expectation has been matched, bounded
  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < budget) begin
      @(negedge Clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d/%0d after %0d cycles, required 0",
               name, exp_q.size(), exp2_q.size(), budget);
      exp_q.delete();
      exp2_q.delete();
    end
  endtask

  task automatic test_reset();
    Reset         = 1'b0;
    sb.req_valid  = 4'($urandom_range(1, 15));
    sb.res_ready  = 1'($urandom_range(0, 1));
    sb2.req_valid = 4'($urandom_range(1, 15));
    sb2.res_ready = 1'($urandom_range(0, 1));
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({sb.req_ready, sb.eng_rst_n, sb.busy, sb.res_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_held_ctrl got=%b required=0", {sb.req_ready, sb.eng_rst_n, sb.busy, sb.res_valid});
    end
    sb.req_valid  = '0;
    sb2.req_valid = '0;
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if ({sb.req_ready, sb.eng_rst_n, sb.eng_sel, sb.busy, sb.res_valid, sb.res_id,
         sb.res_symbols, sb.res_cycles, sb.res_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0",
               {sb.req_ready, sb.eng_rst_n, sb.eng_sel, sb.busy, sb.res_valid, sb.res_id,
                sb.res_symbols, sb.res_cycles, sb.res_timeout});
    end
    checks++;
    if (sb.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d required=0", sb.dbg_state);
    end
    checks++;
    if ({sb2.req_ready, sb2.eng_rst_n, sb2.busy, sb2.res_valid, sb2.dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_dut2 got=%h required=0", {sb2.req_ready, sb2.eng_rst_n, sb2.busy, sb2.res_valid, sb2.dbg_state});
    end
  endtask

  task automatic test_single_job();
    int n = 0, en_cnt = 0, rr_hi = 0;
    done_at      = 100;
    best_val     = {3'd7, 3'd1, 3'd5, 3'd3};
    sb.res_ready = 1'b1;
    exp_q.push_back({2'd2, 12'hE6B, 16'd100, 1'b0});
    @(posedge Clk);
    #1 sb.req_valid = 4'b0100;
    @(negedge Clk);
    checks++;
    if (sb.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_req_ready got=%b required=0100", sb.req_ready);
    end
    @(posedge Clk);
    #1 sb.req_valid = '0;
    checks++;
    if (sb.eng_sel !== 2'd2 || sb.eng_rst_n !== 1'b1 || sb.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant sel=%0d rst_n=%b busy=%b required 2 1 1", sb.eng_sel, sb.eng_rst_n, sb.busy);
    end
    while (!sb.res_valid && n < 300) begin
      @(negedge Clk);
      n++;
      if (sb.eng_rst_n) en_cnt++;
      if (sb.req_ready != 0) rr_hi++;
    end
    checks++;
    if (en_cnt != 100) begin
      errors++;
      $display("FAIL single_eng_rst_n_cycles got=%0d required=100", en_cnt);
    end
    checks++;
    if (rr_hi != 0) begin
      errors++;
      $display("FAIL single_req_ready_extra got=%0d required=0", rr_hi);
    end
    drain("single", 50);
  endtask

  task automatic test_round_robin();
    @(posedge Clk);
    #1 Reset = 1'b0;
    done_at      = 10;
    best_val     = 12'($urandom_range(0, 4095));
    sb.res_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back({2'(i % 4), best_val, 16'd10, 1'b0});
    sb.req_valid = 4'b1111;
    drain("rr_all", 200);
    @(posedge Clk);
    #1 sb.req_valid = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i % 2 == 0) ? 2'd1 : 2'd3, best_val, 16'd10, 1'b0});
    sb.req_valid = 4'b1010;
    drain("rr_pair", 200);
    @(posedge Clk);
    #1 sb.req_valid = '0;
    repeat (2) @(posedge Clk);
  endtask

  task automatic test_timeout();
    sb2.res_ready = 1'b1;
    best_val2     = 12'h123;
    // engine never finishes: abort at the limit
    done_at2 = 0;
    exp2_q.push_back({2'd0, 12'h123, 16'd64, 1'b1});
    @(posedge Clk);
    #1 sb2.req_valid = 4'b0001;
    @(posedge Clk);
    #1 sb2.req_valid = '0;
    drain("timeout_abort", 120);
    // done on the last allowed cycle wins over the timeout
    done_at2 = 64;
    exp2_q.push_back({2'd2, 12'h123, 16'd64, 1'b0});
    @(posedge Clk);
    #1 sb2.req_valid = 4'b0100;
    @(posedge Clk);
    #1 sb2.req_valid = '0;
    drain("timeout_tie", 120);
    // done one cycle before the limit
    done_at2 = 63;
    best_val2 = 12'hA5C;
    exp2_q.push_back({2'd3, 12'hA5C, 16'd63, 1'b0});
    @(posedge Clk);
    #1 sb2.req_valid = 4'b1000;
    @(posedge Clk);
    #1 sb2.req_valid = '0;
    drain("timeout_early", 120);
  endtask

  task automatic test_backpressure();
    int n = 0;
    done_at      = 10;
    best_val     = 12'h5A7;
    sb.res_ready = 1'b0;
    exp_q.push_back({2'd0, 12'h5A7, 16'd10, 1'b0});
    @(posedge Clk);
    #1 sb.req_valid = 4'b0011;
    while (!sb.res_valid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (!sb.res_valid) begin
      errors++;
      $display("FAIL bp_no_result after %0d cycles", n);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checks++;
      if ({sb.res_valid, sb.res_id, sb.res_symbols, sb.res_cycles, sb.res_timeout,
           sb.req_ready, sb.eng_rst_n, sb.busy} !== {1'b1, 2'd0, 12'h5A7, 16'd10, 1'b0, 4'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d valid=%b id=%0d sym=%h cyc=%0d to=%b rdy=%b rst_n=%b busy=%b",
                 i, sb.res_valid, sb.res_id, sb.res_symbols, sb.res_cycles, sb.res_timeout,
                 sb.req_ready, sb.eng_rst_n, sb.busy);
      end
    end
    @(posedge Clk);
    #1 sb.res_ready = 1'b1;
    exp_q.push_back({2'd1, 12'h5A7, 16'd10, 1'b0});
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (sb.req_ready !== 4'b0010 || sb.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle_gap req_ready=%b busy=%b required 0010 0", sb.req_ready, sb.busy);
    end
    @(posedge Clk);
    #1 sb.req_valid = '0;
    checks++;
    if (sb.eng_sel !== 2'd1 || sb.busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_grant sel=%0d busy=%b required 1 1", sb.eng_sel, sb.busy);
    end
    drain("bp", 100);
  endtask

  task automatic test_reset_mid_run();
    done_at      = 50;
    best_val     = 12'h3C9;
    sb.res_ready = 1'b1;
    @(posedge Clk);
    #1 sb.req_valid = 4'b0100;
    @(posedge Clk);
    repeat (29) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({sb.req_ready, sb.eng_rst_n, sb.eng_sel, sb.busy, sb.res_valid, sb.dbg_state} !== '0) begin
      errors++;
      $display("FAIL midrun_async_reset got=%h required=0",
               {sb.req_ready, sb.eng_rst_n, sb.eng_sel, sb.busy, sb.res_valid, sb.dbg_state});
    end
    repeat (3) @(posedge Clk);
    exp_q.push_back({2'd2, 12'h3C9, 16'd50, 1'b0});
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 sb.req_valid = '0;
    checks++;
    if (sb.eng_sel !== 2'd2 || sb.eng_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL midrun_regrant sel=%0d rst_n=%b required 2 1", sb.eng_sel, sb.eng_rst_n);
    end
    drain("midrun", 150);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    done_at       = 0;
    done_at2      = 0;
    test_reset();
    test_single_job();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid_run();
    repeat (3) @(posedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
